// File: rtl/alu_branch_if.sv
// Branch-resolution request/result bundle between a fetch stage and alu_branch.
// Latency: none (wires only); the result side is registered inside alu_branch.
// Backpressure: none; a request is presented with in_valid and always accepted.
interface alu_branch_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 5
);
  // request side
  logic             in_valid;
  logic [PC_W-1:0]  PC_Curr;
  logic [OFF_W-1:0] offset;
  logic             taken;
  // result side
  logic [PC_W-1:0]  PC_New;
  logic             out_valid;
  logic             wrap;

  // requester: drives a request, observes the resolved PC
  modport master (
    output in_valid, PC_Curr, offset, taken,
    input  PC_New, out_valid, wrap
  );

  // resolver: consumes a request, produces the resolved PC
  modport slave (
    input  in_valid, PC_Curr, offset, taken,
    output PC_New, out_valid, wrap
  );
endinterface

// File: rtl/alu_branch.sv
// Next-PC resolver: PC_Curr + sext(offset) when taken, else PC_Curr + 1, modulo 2^PC_W.
// Latency: one cycle, request sampled at edge N shows on PC_New/wrap/out_valid after edge N.
// Backpressure: none; one request per cycle, nothing queued. Optional ALU_BRANCH_WRAP_DETECT_EN adds wrap.
module alu_branch #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 5
) (
  input logic          clk,
  input logic          reset,
  alu_branch_if.slave  bus
);

`ifdef ALU_BRANCH_WRAP_DETECT_EN
  // Two guard bits above the PC: with a zero-extended PC and a sign-extended
  // step, any non-zero guard bit means the true sum left 0..2^PC_W-1.
  localparam int SUM_W = PC_W + 2;
`else
  localparam int SUM_W = PC_W;
`endif

  logic [SUM_W-1:0] step;
  logic [SUM_W-1:0] sum;
  logic [PC_W-1:0]  pc_new_q;
  logic             out_valid_q;

  // One shared adder: the fall-through path is just a step of +1.
  always_comb begin
    step = SUM_W'(1);
    if (bus.taken) begin
      step = SUM_W'($signed(bus.offset));
    end
    sum = SUM_W'(bus.PC_Curr) + step;
  end

  // Result register: updates only on an accepted request, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_new_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        pc_new_q <= sum[PC_W-1:0];
      end
    end
  end

`ifdef ALU_BRANCH_WRAP_DETECT_EN
  logic wrap_q;

  // Wrap flag registered alongside PC_New so the pair always belongs together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else if (bus.in_valid) begin
      wrap_q <= |sum[SUM_W-1:PC_W];
    end
  end

  assign bus.wrap = wrap_q;
`else
  assign bus.wrap = 1'b0;
`endif

  assign bus.PC_New    = pc_new_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_branch.sv
// Self-checking bench for alu_branch: reference model plus directed literal vectors.
// Latency: expects results one cycle after each accepted request.
// Backpressure: none expected; requests are issued back-to-back.
module tb_alu_branch;
  localparam int PC_W  = 8;
  localparam int OFF_W = 5;
`ifdef ALU_BRANCH_WRAP_DETECT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_branch_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  alu_branch #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the architectural rule.
  logic [PC_W-1:0] m_pc;
  logic            m_wrap;
  logic            m_vld;
  logic            m_init;

  initial m_init = 1'b0;

  always @(posedge clk) begin
    int t;
    int md;
    int r;
    if (reset) begin
      m_pc   = '0;
      m_wrap = 1'b0;
      m_vld  = 1'b0;
      m_init = 1'b1;
    end else begin
      m_vld = bus.in_valid;
      if (bus.in_valid) begin
        md = 1 << PC_W;
        if (bus.taken) t = int'(bus.PC_Curr) + int'($signed(bus.offset));
        else           t = int'(bus.PC_Curr) + 1;
        r = t % md;
        if (r < 0) r = r + md;
        m_pc   = PC_W'(r);
        m_wrap = WD && (t < 0 || t >= md);
      end
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_init) begin
      checks = checks + 1;
      if (bus.out_valid !== m_vld || bus.PC_New !== m_pc || bus.wrap !== m_wrap) begin
        errors = errors + 1;
        $display("FAIL model t=%0t got vld=%b pc=%h wrap=%b want vld=%b pc=%h wrap=%b",
                 $time, bus.out_valid, bus.PC_New, bus.wrap, m_vld, m_pc, m_wrap);
      end
    end
  end

  task automatic check_lit(input string name, input logic vld,
                           input logic [PC_W-1:0] pc, input logic wr);
    checks = checks + 1;
    if (bus.out_valid !== vld || bus.PC_New !== pc || bus.wrap !== wr) begin
      errors = errors + 1;
      $display("FAIL %s got vld=%b pc=%h wrap=%b want vld=%b pc=%h wrap=%b",
               name, bus.out_valid, bus.PC_New, bus.wrap, vld, pc, wr);
    end
  endtask

  // Present a request now (away from the edge), then check its result one cycle later.
  task automatic send(input string name, input logic [PC_W-1:0] pc,
                      input logic [OFF_W-1:0] off, input logic tk,
                      input logic [PC_W-1:0] exp_pc, input logic exp_wr);
    bus.in_valid = 1'b1;
    bus.PC_Curr  = pc;
    bus.offset   = off;
    bus.taken    = tk;
    @(negedge clk);
    check_lit(name, 1'b1, exp_pc, exp_wr & WD);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.PC_Curr  = '0;
    bus.offset   = '0;
    bus.taken    = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("reset_state", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;

    // back-to-back directed vectors
    send("neg16_to_zero", 8'h10, 5'b10000, 1'b1, 8'h00, 1'b0);
    send("off_zero",      8'h04, 5'b00000, 1'b1, 8'h04, 1'b0);
    send("plus5",         8'h02, 5'b00101, 1'b1, 8'h07, 1'b0);
    send("plus1",         8'h0F, 5'b00001, 1'b1, 8'h10, 1'b0);
    send("minus15_wrap",  8'h02, 5'b10001, 1'b1, 8'hF3, 1'b1);
    send("fall_ff",       8'hFF, 5'b00011, 1'b0, 8'h00, 1'b1);
    send("fall_20",       8'h20, 5'b10101, 1'b0, 8'h21, 1'b0);
    send("zero_minus1",   8'h00, 5'b11111, 1'b1, 8'hFF, 1'b1);
    send("ff_plus1",      8'hFF, 5'b00001, 1'b1, 8'h00, 1'b1);
    send("f0_plus15",     8'hF0, 5'b01111, 1'b1, 8'hFF, 1'b0);
    send("f1_plus15",     8'hF1, 5'b01111, 1'b1, 8'h00, 1'b1);

    // idle: valid drops, result held even with changing inputs
    bus.in_valid = 1'b0;
    bus.PC_Curr  = 8'h33;
    @(negedge clk);
    check_lit("idle_hold", 1'b0, 8'h00, WD);

    // model-checked sweep with idle gaps
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.PC_Curr  = PC_W'($urandom);
      bus.offset   = OFF_W'($urandom);
      bus.taken    = 1'($urandom);
      @(negedge clk);
    end

    // reset together with a request: request discarded
    bus.in_valid = 1'b1;
    bus.PC_Curr  = 8'h55;
    bus.offset   = 5'b00011;
    bus.taken    = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    check_lit("reset_vs_req", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    send("after_reset", 8'h80, 5'b00010, 1'b1, 8'h82, 1'b0);

    // request in flight when reset asserts: no pulse after release
    send("inflight_req", 8'hFE, 5'b00101, 1'b1, 8'h03, 1'b1);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check_lit("inflight_reset", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_lit("inflight_release", 1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_branch.md
ALU_BRANCH -- requirements
Module: alu_branch

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter OFF_W, default 5, meaning branch-offset width in bits, with OFF_W <= PC_W.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request strobe; PC_Curr, offset and taken are sampled when high.
REQ-007 PC_Curr  input  PC_W  current program counter, unsigned.
REQ-008 offset  input  OFF_W  branch offset, two's complement signed.
REQ-009 taken  input  1  branch condition; 1 selects the branch target, 0 selects the fall-through address.
REQ-010 PC_New  output  PC_W  next program counter, registered.
REQ-011 out_valid  output  1  high for exactly one cycle when PC_New holds a new result.
REQ-012 wrap  output  1  target address crossed the 0/2^PC_W boundary, registered.

Function
REQ-013 Branch target SHALL be PC_Curr + sign_extend(offset, PC_W), computed modulo 2^PC_W.
REQ-014 The offset range SHALL be -2^(OFF_W-1)..2^(OFF_W-1)-1 (defaults -16..+15); the MSB is the sign bit.
REQ-015 The offset SHALL be relative to PC_Curr itself, not PC_Curr+1; offset 0 yields PC_Curr.
REQ-016 With taken=0, the block SHALL produce PC_Curr + 1 modulo 2^PC_W.
REQ-017 Latency SHALL be one cycle: inputs sampled at edge N with in_valid=1 appear on PC_New/wrap with out_valid=1 after edge N.
REQ-018 A new request SHALL be accepted every cycle, with no backpressure and no internal queueing.
REQ-019 When in_valid=0, PC_New and wrap SHALL hold their previous values and out_valid SHALL be 0.
REQ-020 The wrap bit SHALL be 1 when the true signed sum is < 0 or > 2^PC_W-1, including the fall-through path 0xFF+1 -> 0x00; otherwise it SHALL be 0.
REQ-021 Boundary handling: PC_Curr=0 with offset=-1 SHALL give PC_New=0xFF and wrap=1; PC_Curr=0xFF with offset=+1 SHALL give 0x00 and wrap=1; PC_Curr=0x10 with offset=-16 SHALL give 0x00 and wrap=0.
REQ-022 The datapath SHALL contain no latches and no combinational path from inputs to outputs.

Reset
REQ-023 When reset=1 at a rising clk edge, PC_New SHALL be 0, wrap SHALL be 0 and out_valid SHALL be 0.
REQ-024 Reset SHALL take priority over in_valid in the same cycle; a request presented during reset SHALL be discarded.
REQ-025 A request in flight when reset asserts SHALL be dropped, with no out_valid pulse after reset release.

Configuration
REQ-026 Macro ALU_BRANCH_WRAP_DETECT_EN: when defined, wrap SHALL be computed per REQ-020.
REQ-027 When ALU_BRANCH_WRAP_DETECT_EN is not defined, wrap SHALL be tied to 0 and no wrap-detection logic SHALL be synthesized; PC_New and out_valid SHALL be unaffected.

Verification
REQ-028 PC_Curr=0x10, offset=5'b10000, taken=1, in_valid=1 -> next cycle PC_New=0x00, wrap=0, out_valid=1.
REQ-029 PC_Curr=0x04, offset=0 -> PC_New=0x04; PC_Curr=0x02, offset=5'b00101 -> PC_New=0x07, both taken=1.
REQ-030 PC_Curr=0x0F, offset=5'b00001 -> PC_New=0x10; PC_Curr=0x02, offset=5'b10001 (-15) -> PC_New=0xF3, wrap=1 (0 with macro undefined).
REQ-031 taken=0 with PC_Curr=0xFF -> PC_New=0x00, wrap=1; taken=0 with PC_Curr=0x20 and any offset -> PC_New=0x21.
REQ-032 Back-to-back requests on consecutive cycles -> one result per cycle in order; an idle cycle with in_valid=0 -> out_valid=0 and PC_New held.
REQ-033 reset=1 together with in_valid=1 -> PC_New=0x00, wrap=0, out_valid=0 on the following cycle.
